// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the execute_md stage
package exec_pkg;
  localparam logic [5:0] ALU_ADD = 6'd0, ALU_SUB = 6'd1, ALU_AND = 6'd2, ALU_OR = 6'd3,
                         ALU_XOR = 6'd4, ALU_NOR = 6'd5, ALU_SLT = 6'd6, ALU_SLTU = 6'd7,
                         ALU_SLL = 6'd8, ALU_SRL = 6'd9, ALU_SRA = 6'd10, ALU_LUI = 6'd11;
  localparam logic [1:0] FWD_IDEX = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2, FWD_ZERO = 2'd3;
  typedef enum logic [2:0] {MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO} md_op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} md_state_t;
endpackage

// File: rtl/execute_md_muldiv_iter.sv
// muldiv_iter: iterative shift-add multiplier / restoring divider owning HI and LO
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int CW = $clog2(DATA_W);
  md_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2*DATA_W-1:0] p, pm;
  logic [DATA_W-1:0] m, ma, mb, q_s, r_s;
  logic [DATA_W:0] add, sub;
  logic is_div, neg, neg_r, dz, sgn, sa, sb, div_op, last;
  assign div_op = op == MD_DIV || op == MD_DIVU;
  assign sgn = op == MD_MULT || op == MD_DIV;
  assign sa = sgn & a[DATA_W-1];
  assign sb = sgn & b[DATA_W-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign add = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, m} : '0);
  assign sub = p[2*DATA_W-1:DATA_W-1] - {1'b0, m};
  assign pm = neg ? -p : p;
  assign q_s = dz ? '1 : neg ? -p[DATA_W-1:0] : p[DATA_W-1:0];
  assign r_s = neg_r ? -p[2*DATA_W-1:DATA_W] : p[2*DATA_W-1:DATA_W];
  assign last = cnt == CW'(DATA_W - 1);
  assign busy = state != S_IDLE;
  always_comb begin
    nxt = state == S_IDLE ? (start ? (div_op ? S_DIV : S_MUL) : S_IDLE) : state == S_FIX ? S_IDLE : last ? S_FIX : state;
  end
  always_ff @(posedge clk) state <= rst ? S_IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      p <= '0;
      m <= '0;
      is_div <= 1'b0;
      neg <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        cnt <= '0;
        is_div <= div_op;
        neg <= sa ^ sb;
        neg_r <= sa;
        dz <= b == '0;
        m <= div_op ? mb : ma;
        p <= {{DATA_W{1'b0}}, div_op ? ma : mb};
      end
    end else if (state == S_FIX) begin
      hi <= is_div ? r_s : pm[2*DATA_W-1:DATA_W];
      lo <= is_div ? q_s : pm[DATA_W-1:0];
    end else begin
      cnt <= cnt + 1'b1;
      p <= is_div ? (sub[DATA_W] ? {p[2*DATA_W-2:0], 1'b0} : {sub[DATA_W-1:0], p[DATA_W-2:0], 1'b1}) : {add, p[DATA_W-1:1]};
    end
  end
endmodule

// File: rtl/execute_md.sv
// execute_md: MIPS EX stage with iterative mul/div, HI/LO, stall interlock and EX/MEM register
module execute_md
  import exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic [DATA_W-1:0]     i_srcA,
  input  logic [DATA_W-1:0]     i_srcB,
  input  logic [DATA_W-1:0]     i_dato2,
  input  logic [DATA_W-1:0]     i_pcplus4,
  input  logic [31:0]           i_instruction,
  input  logic [5:0]            i_ALUOp,
  input  logic [2:0]            i_mdOp,
  input  logic                  i_regDst,
  input  logic                  i_gpr31,
  input  logic                  i_takeBranch,
  input  logic                  i_typeBranch,
  input  logic                  i_takeJumpR,
  input  logic                  i_memToReg,
  input  logic                  i_regWrite,
  input  logic                  i_memWrite,
  input  logic                  i_memRead,
  input  logic [1:0]            i_fwd_a_sel,
  input  logic [1:0]            i_fwd_b_sel,
  input  logic [1:0]            i_fwd_c_sel,
  input  logic [DATA_W-1:0]     i_fwd_dato_mem,
  input  logic [DATA_W-1:0]     i_fwd_dato_wb,
  output logic                  o_stall,
  output logic                  o_takeBranch,
  output logic [DATA_W-1:0]     o_branchAddress,
  output logic                  o_takeJumpR,
  output logic [DATA_W-1:0]     o_jumpAddressR,
  output logic                  o_valid,
  output logic [DATA_W-1:0]     o_pcplus4,
  output logic [DATA_W-1:0]     o_result,
  output logic                  o_carry,
  output logic [DATA_W-1:0]     o_dato2,
  output logic [REG_ADDR_W-1:0] o_writeRegister,
  output logic                  o_memToReg,
  output logic                  o_regWrite,
  output logic                  o_memWrite,
  output logic                  o_memRead
);
  localparam int SW = $clog2(DATA_W);
  logic [DATA_W-1:0] a, b, c, alu, hi, lo, sext;
  logic [REG_ADDR_W-1:0] wreg;
  logic carry, zero, live, busy, start, kill, md_start_op, unused_bits;
  function automatic logic [DATA_W-1:0] fwd(input logic [1:0] sel, input logic [DATA_W-1:0] idex, mem, wb);
    return sel == FWD_IDEX ? idex : sel == FWD_MEM ? mem : sel == FWD_WB ? wb : '0;
  endfunction
  assign a = fwd(i_fwd_a_sel, i_srcA, i_fwd_dato_mem, i_fwd_dato_wb);
  assign b = fwd(i_fwd_b_sel, i_srcB, i_fwd_dato_mem, i_fwd_dato_wb);
  assign c = fwd(i_fwd_c_sel, i_dato2, i_fwd_dato_mem, i_fwd_dato_wb);
  assign unused_bits = ^i_instruction[31:21];
  assign live = i_valid & ~i_flush;
  assign md_start_op = i_mdOp inside {[3'd1:3'd4]};
  assign o_stall = live & busy & (i_mdOp inside {[3'd1:3'd6]});
  assign start = live & ~busy & md_start_op;
  assign kill = ~live | o_stall | md_start_op;
  always_comb begin
    {carry, alu} = '0;
    case (i_ALUOp)
      ALU_SUB:  {carry, alu} = {1'b0, a} - {1'b0, b};
      ALU_AND:  alu = a & b;
      ALU_OR:   alu = a | b;
      ALU_XOR:  alu = a ^ b;
      ALU_NOR:  alu = ~(a | b);
      ALU_SLT:  alu = DATA_W'($signed(a) < $signed(b));
      ALU_SLTU: alu = DATA_W'(a < b);
      ALU_SLL:  alu = b << a[SW-1:0];
      ALU_SRL:  alu = b >> a[SW-1:0];
      ALU_SRA:  alu = DATA_W'($signed(b) >>> a[SW-1:0]);
      ALU_LUI:  alu = b << (DATA_W / 2);
      default:  {carry, alu} = {1'b0, a} + {1'b0, b};
    endcase
  end
  assign zero = alu == '0;
  assign sext = DATA_W'($signed(i_instruction[15:0]));
  assign o_takeBranch = live & i_takeBranch & (i_typeBranch ? ~zero : zero);
  assign o_branchAddress = i_pcplus4 + (sext << 2);
  assign o_takeJumpR = live & i_takeJumpR;
  assign o_jumpAddressR = a;
  assign wreg = i_gpr31 ? '1 : i_regDst ? REG_ADDR_W'(i_instruction[15:11]) : REG_ADDR_W'(i_instruction[20:16]);
  muldiv_iter #(.DATA_W(DATA_W)) u_md (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(i_mdOp),
    .a(a),
    .b(b),
    .busy(busy),
    .hi(hi),
    .lo(lo)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_pcplus4 <= '0;
      o_result <= '0;
      o_carry <= 1'b0;
      o_dato2 <= '0;
      o_writeRegister <= '0;
      o_memToReg <= 1'b0;
      o_regWrite <= 1'b0;
      o_memWrite <= 1'b0;
      o_memRead <= 1'b0;
    end else begin
      o_valid <= ~kill;
      o_pcplus4 <= i_pcplus4;
      o_result <= i_mdOp == MD_MFHI ? hi : i_mdOp == MD_MFLO ? lo : alu;
      o_carry <= carry;
      o_dato2 <= c;
      o_writeRegister <= wreg;
      o_memToReg <= i_memToReg & ~kill;
      o_regWrite <= i_regWrite & ~kill;
      o_memWrite <= i_memWrite & ~kill;
      o_memRead <= i_memRead & ~kill;
    end
  end
endmodule
